// File: rtl/dlp_pkg.sv
// dlp_pkg: shared widths and slot type for the dual-lane pipeline.
package dlp_pkg;
   localparam int DATA_W    = 32;
   localparam int CNT_W     = 16;
   localparam int NUM_LANES = 2;
   typedef logic lane_idx_t;
   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] d;
   } slot_t;
endpackage

// File: rtl/dual_lane_pipeline_pipe_lane.sv
// pipe_lane: fixed-latency scaling lane with emission counter.
module pipe_lane
   import dlp_pkg::*;
#(
   parameter int          STAGES = 4,
   parameter int unsigned COEFF  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              in_v,
   input  logic [DATA_W-1:0] in_d,
   output logic              out_v,
   output logic [DATA_W-1:0] out_d,
   output logic [CNT_W-1:0]  emit_cnt
);
   slot_t             s [STAGES];
   logic [DATA_W-1:0] prod;
   assign prod  = s[0].d * DATA_W'(COEFF);
   assign out_v = s[STAGES-1].v && !hold && !reset;
   assign out_d = out_v ? s[STAGES-1].d : '0;
   // hold freezes every slot and the counter together so nothing is lost or repeated
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) s[i] <= '0;
         emit_cnt <= '0;
      end else if (!hold) begin
         s[0] <= '{v: in_v, d: in_d};
         s[1] <= '{v: s[0].v, d: prod};
         for (int i = 2; i < STAGES; i++) s[i] <= s[i-1];
         emit_cnt <= emit_cnt + CNT_W'(out_v);
      end
   end
endmodule

// File: rtl/dual_lane_pipeline.sv
// dual_lane_pipeline: round-robin / duplicate dispatch of a word stream into two scaling lanes.
module dual_lane_pipeline
   import dlp_pkg::*;
#(
   parameter int          STAGES = 4,
   parameter int unsigned COEFF0 = 3,
   parameter int unsigned COEFF1 = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              dup,
   input  logic              hold,
   output logic [DATA_W-1:0] pipeline1_outputs,
   output logic [DATA_W-1:0] pipeline2_outputs,
   output logic [1:0]        valid,
   output logic [CNT_W-1:0]  emit_cnt0,
   output logic [CNT_W-1:0]  emit_cnt1
);
   lane_idx_t rr;
   logic      acc;
   assign in_ready = !hold && !reset;
   assign acc      = in_valid && in_ready;
   always_ff @(posedge clk) begin
      if (reset) rr <= 1'b0;
      else if (acc && !dup) rr <= ~rr;
   end
   pipe_lane #(.STAGES(STAGES), .COEFF(COEFF0)) u_lane0 (
      .clk(clk), .reset(reset), .hold(hold),
      .in_v(acc && (dup || rr == 1'b0)), .in_d(in_data),
      .out_v(valid[0]), .out_d(pipeline1_outputs), .emit_cnt(emit_cnt0)
   );
   pipe_lane #(.STAGES(STAGES), .COEFF(COEFF1)) u_lane1 (
      .clk(clk), .reset(reset), .hold(hold),
      .in_v(acc && (dup || rr == 1'b1)), .in_d(in_data),
      .out_v(valid[1]), .out_d(pipeline2_outputs), .emit_cnt(emit_cnt1)
   );
endmodule

// File: tb/tb_dual_lane_pipeline.sv
// tb_dual_lane_pipeline: age-based reference model plus directed vectors.
module tb_dual_lane_pipeline;
   localparam int STAGES = 4;
   localparam logic [31:0] C0 = 32'd3;
   localparam logic [31:0] C1 = 32'd5;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, dup = 1'b0, hold = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic [31:0] pipeline1_outputs, pipeline2_outputs;
   logic [1:0]  valid;
   logic [15:0] emit_cnt0, emit_cnt1;
   always #5 clk = ~clk;
   dual_lane_pipeline #(.STAGES(STAGES), .COEFF0(3), .COEFF1(5)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .dup(dup), .hold(hold), .pipeline1_outputs(pipeline1_outputs),
      .pipeline2_outputs(pipeline2_outputs), .valid(valid),
      .emit_cnt0(emit_cnt0), .emit_cnt1(emit_cnt1)
   );
   typedef struct {
      int          age;
      logic [31:0] d;
   } ent_t;
   ent_t        q [2][$];
   int          rr_m = 0;
   logic [15:0] cnt_m [2];
   bit          started = 0;
   int          n_cmp = 0, n_bad = 0;
   function automatic logic [31:0] coeff(int l);
      return l == 0 ? C0 : C1;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // A word's age counts the unheld edges since it was accepted; it emits at age STAGES.
   initial forever begin
      @(posedge clk);
      if (reset) begin
         q[0].delete();
         q[1].delete();
         rr_m = 0;
         cnt_m[0] = '0;
         cnt_m[1] = '0;
         started = 1;
      end else if (!hold) begin
         for (int l = 0; l < 2; l++)
            for (int k = q[l].size() - 1; k >= 0; k--)
               if (q[l][k].age == STAGES) begin
                  cnt_m[l] = cnt_m[l] + 16'd1;
                  q[l].delete(k);
               end else q[l][k].age++;
         if (in_valid) begin
            if (dup) begin
               q[0].push_back('{age: 1, d: in_data});
               q[1].push_back('{age: 1, d: in_data});
            end else begin
               q[rr_m].push_back('{age: 1, d: in_data});
               rr_m = 1 - rr_m;
            end
         end
      end
   end
   initial forever begin : cmp
      logic [1:0]  ev;
      logic [31:0] ed [2];
      @(negedge clk);
      if (reset) chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      else if (started) begin
         ev = '0;
         ed[0] = '0;
         ed[1] = '0;
         for (int l = 0; l < 2; l++)
            foreach (q[l][k])
               if (q[l][k].age == STAGES && !hold) begin
                  ev[l] = 1'b1;
                  ed[l] = q[l][k].d * coeff(l);
               end
         chk("model_valid", 32'(valid), 32'(ev));
         chk("model_out1", pipeline1_outputs, ed[0]);
         chk("model_out2", pipeline2_outputs, ed[1]);
         chk("model_cnt0", 32'(emit_cnt0), 32'(cnt_m[0]));
         chk("model_cnt1", 32'(emit_cnt1), 32'(cnt_m[1]));
         chk("model_in_ready", 32'(in_ready), 32'(!hold));
      end
   end
   task automatic cyc(input logic v, input logic [31:0] d, input logic dp, input logic h, input logic r);
      @(posedge clk);
      #1;
      in_valid = v;
      in_data  = d;
      dup      = dp;
      hold     = h;
      reset    = r;
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic do_reset();
      repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask
   initial begin
      do_reset();
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_cnt0", 32'(emit_cnt0), 32'd0);
      // round-robin pair
      cyc(1, 32'h10, 0, 0, 0);
      cyc(1, 32'h20, 0, 0, 0);
      idle(3);
      chk("t1_valid_t4", 32'(valid), 32'd1);
      chk("t1_out1_t4", pipeline1_outputs, 32'h30);
      idle(1);
      chk("t1_valid_t5", 32'(valid), 32'd2);
      chk("t1_out2_t5", pipeline2_outputs, 32'hA0);
      idle(1);
      chk("t1_cnt0", 32'(emit_cnt0), 32'd1);
      chk("t1_cnt1", 32'(emit_cnt1), 32'd1);
      // duplicate, then rr unchanged
      cyc(1, 32'h7, 1, 0, 0);
      idle(4);
      chk("t2_valid", 32'(valid), 32'd3);
      chk("t2_out1", pipeline1_outputs, 32'h15);
      chk("t2_out2", pipeline2_outputs, 32'h23);
      cyc(1, 32'h9, 0, 0, 0);
      idle(4);
      chk("t2_after_dup_lane0", 32'(valid), 32'd1);
      chk("t2_after_dup_out1", pipeline1_outputs, 32'h1B);
      // hold stretches latency
      do_reset();
      cyc(1, 32'h10, 0, 0, 0);
      idle(1);
      repeat (3) begin
         cyc(0, '0, 0, 1, 0);
         chk("t3_hold_valid", 32'(valid), 32'd0);
         chk("t3_hold_ready", 32'(in_ready), 32'd0);
      end
      idle(2);
      chk("t3_valid_t6", 32'(valid), 32'd0);
      idle(1);
      chk("t3_valid_t7", 32'(valid), 32'd1);
      chk("t3_out1_t7", pipeline1_outputs, 32'h30);
      idle(1);
      chk("t3_cnt0", 32'(emit_cnt0), 32'd1);
      // data and counter wrap
      do_reset();
      cyc(1, 32'hFFFF_FFFF, 0, 0, 0);
      idle(4);
      chk("t4_data_wrap", pipeline1_outputs, 32'hFFFF_FFFD);
      do_reset();
      for (int i = 0; i < 65535; i++) cyc(1, 32'(i), 1, 0, 0);
      idle(5);
      chk("t4_cnt1_full", 32'(emit_cnt1), 32'h0000_FFFF);
      cyc(1, 32'h1, 1, 0, 0);
      idle(5);
      chk("t4_cnt1_wrap", 32'(emit_cnt1), 32'd0);
      chk("t4_cnt0_wrap", 32'(emit_cnt0), 32'd0);
      // reset mid-flight
      do_reset();
      cyc(1, 32'h11, 0, 0, 0);
      cyc(1, 32'h22, 0, 0, 0);
      cyc(0, '0, 0, 0, 1);
      repeat (8) begin
         idle(1);
         chk("t5_no_stale_valid", 32'(valid), 32'd0);
         chk("t5_out1_zero", pipeline1_outputs, 32'd0);
         chk("t5_out2_zero", pipeline2_outputs, 32'd0);
      end
      cyc(1, 32'h5, 0, 0, 0);
      idle(4);
      chk("t5_lane0_after_reset", 32'(valid), 32'd1);
      chk("t5_out1", pipeline1_outputs, 32'hF);
      // back-to-back stream
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(i < 8, 32'(i + 1), 0, 0, 0);
         if (i >= 4) chk("t6_alternate", 32'(valid), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      idle(1);
      chk("t6_cnt0", 32'(emit_cnt0), 32'd4);
      chk("t6_cnt1", 32'(emit_cnt1), 32'd4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
